program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Sequences writes of a program image into Jimmy program memory from a byte stream (UART receiver).
//  Arbitrates the memory address port between the CPU fetch path and the loader.
//  Holds the CPU while loading; releases it only after a checksum-verified image.
//  Sits between the UART RX, the CPU fetch bus and program memory's read/write ports.
// PARAMETERS
//  SYNC_BYTE       8'hA5    frame start marker
//  TIMEOUT_CYCLES  1000000  max idle clocks between bytes once a frame has started
//  NOP_BYTE        8'h70    instruction fed to the CPU while held
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  reset        in   1  reset, synchronous, active-low
//  load_req     in   1  one-cycle request to start a load
//  rx_data      in   8  received byte
//  rx_valid     in   1  rx_data valid
//  rx_ready     out  1  loader accepts the byte this cycle
//  cpu_address  in   8  CPU fetch address
//  cpu_data     out  8  fetched instruction byte to the CPU
//  mem_addr     out  8  program memory address
//  mem_wdata    out  8  program memory write data
//  mem_we       out  1  program memory write enable
//  mem_rdata    in   8  program memory read data (combinational read)
//  cpu_hold     out  1  holds the CPU in reset / stall
//  busy         out  1  loader is not in IDLE
//  done         out  1  one-cycle pulse on a successful load
//  error        out  1  sticky: bad checksum or timeout
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; rx_ready=0, mem_we=0, cpu_hold=0, busy=0, done=0,
//   error=0; counters cleared. A reset mid-load abandons the frame; the partial image stays in memory.
//  Accept = rx_valid & rx_ready. rx_ready=1 exactly in SYNC, LEN, DATA and CSUM. Accepting one byte per cycle is legal.
//  FSM:
//   IDLE: load_req -> SYNC; set cpu_hold=1 and busy=1, clear error, ptr=0, sum=0.
//   SYNC: a byte equal to SYNC_BYTE -> LEN; any other byte is discarded and the FSM stays in SYNC. No timeout in SYNC.
//   LEN:  store the byte as len; len==0 means 256 bytes -> DATA.
//   DATA: on each accept: register mem_addr=ptr, mem_wdata=byte, mem_we=1 for exactly 1 cycle
//         (write lands 1 cycle after accept); sum=sum+byte mod 256; ptr=ptr+1.
//         After the len-th byte -> CSUM. The 8-bit ptr wraps 255->0 only when len=256.
//   CSUM: if byte==sum -> DONE, else -> ERR.
//   DONE: for 1 cycle done=1; next cycle cpu_hold=0, busy=0 -> IDLE.
//   ERR:  error=1, cpu_hold stays 1, busy=0. load_req -> SYNC (clears error); otherwise stays in ERR.
//  Timeout: the idle counter resets on every accept and on entry to LEN.
//   Reaching TIMEOUT_CYCLES in LEN, DATA or CSUM -> ERR.
//  load_req is ignored in SYNC, LEN, DATA, CSUM and DONE.
//  Address mux:
//   cpu_hold=0: mem_addr=cpu_address, mem_we=0, cpu_data=mem_rdata.
//   cpu_hold=1: mem_addr=loader address register, cpu_data=NOP_BYTE.
//  An accept and a timeout in the same cycle: the accept wins.
// STRUCTURE
//  Shared package jimmy_pkg: opcode constants, NOP_BYTE, SYNC_BYTE, loader state encoding.
//  One sub-module, loader_timeout: loadable down-counter with clear and expired outputs.
//  The FSM, checksum and mux live in program_loader.
// TESTING
//  1 Frame A5,03,11,22,33,66 -> writes 11@0, 22@1, 33@2; done pulses once; cpu_hold falls the next cycle; error=0.
//  2 Same frame with checksum 67 -> no done; error=1; cpu_hold stays 1; a new load_req clears error.
//  3 Bytes 00,FF,A5,01,7F,7F before SYNC_BYTE -> 00 and FF discarded; 7F@0; done pulses.
//  4 len=00, 256 bytes i=0..255, checksum 80 -> all 256 addresses written; ptr wraps; done pulses.
//  5 Stall TIMEOUT_CYCLES after the 2nd data byte -> ERR with error=1; a late byte is not written.
//  6 reset low mid-DATA -> all outputs at reset values the next cycle; cpu_address routes to mem_addr;
//    load_req while busy is ignored.

Source files
------------

// File: rtl/jimmy_pkg.sv
// Shared Jimmy definitions: opcode constants, loader framing bytes and the
// program loader state encoding.
package jimmy_pkg;

   localparam logic [7:0] OPC_NOP        = 8'h70;
   localparam logic [7:0] JIMMY_NOP_BYTE  = OPC_NOP;
   localparam logic [7:0] JIMMY_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      LD_IDLE = 3'd0,
      LD_SYNC = 3'd1,
      LD_LEN  = 3'd2,
      LD_DATA = 3'd3,
      LD_CSUM = 3'd4,
      LD_DONE = 3'd5,
      LD_ERR  = 3'd6
   } loader_state_t;

   // States in which the loader takes bytes from the receiver.
   function automatic logic is_rx_state(input loader_state_t s);
      return (s == LD_SYNC) || (s == LD_LEN) || (s == LD_DATA) || (s == LD_CSUM);
   endfunction

   // States guarded by the inter-byte idle timeout (SYNC waits forever).
   function automatic logic is_timed_state(input loader_state_t s);
      return (s == LD_LEN) || (s == LD_DATA) || (s == LD_CSUM);
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// Loadable idle down-counter; expired is high once CYCLES idle clocks have
// elapsed since the last load.
module loader_timeout #(
   parameter int unsigned CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int unsigned TW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
   // Reload with CYCLES-1 so the state machine sees expired during the
   // CYCLES-th idle clock and leaves on that clock's closing edge.
   localparam logic [TW-1:0] RELOAD = TW'(CYCLES - 1);

   logic [TW-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= RELOAD;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/program_loader.sv
// Loads a framed, checksummed program image from the UART into program memory
// and owns the memory address port (and holds the CPU) while doing so.
module program_loader
   import jimmy_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE      = JIMMY_SYNC_BYTE,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  NOP_BYTE       = JIMMY_NOP_BYTE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_req,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   input  logic [7:0] cpu_address,
   output logic [7:0] cpu_data,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   input  logic [7:0] mem_rdata,
   output logic       cpu_hold,
   output logic       busy,
   output logic       done,
   output logic       error
);

   // Handshake: a byte transfers on a rising clk when rx_valid and rx_ready
   // are both high; rx_ready depends only on the registered state, never on
   // rx_valid, and one transfer per cycle is allowed.

   loader_state_t state;
   logic [7:0]    ptr;
   logic [7:0]    sum;
   logic [8:0]    remaining;
   logic [7:0]    addr_q;
   logic [7:0]    wdata_q;
   logic          we_q;
   logic          done_q;
   logic          error_q;
   logic          accept;
   logic          expired;
   logic          tmo_clear;

   assign rx_ready  = is_rx_state(state);
   assign accept    = rx_valid & rx_ready;
   assign tmo_clear = (state == LD_IDLE) || (state == LD_ERR);

   loader_timeout #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmo_clear),
      .load    (accept),
      .enable  (is_timed_state(state)),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= LD_IDLE;
         ptr       <= '0;
         sum       <= '0;
         remaining <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         case (state)
            LD_IDLE, LD_ERR: begin
               if (load_req) begin
                  state   <= LD_SYNC;
                  error_q <= 1'b0;
                  ptr     <= '0;
                  sum     <= '0;
               end
            end
            LD_SYNC: begin
               if (accept && (rx_data == SYNC_BYTE)) begin
                  state <= LD_LEN;
               end
            end
            LD_LEN: begin
               if (accept) begin
                  remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                  state     <= LD_DATA;
               end else if (expired) begin
                  state   <= LD_ERR;
                  error_q <= 1'b1;
               end
            end
            LD_DATA: begin
               // The write is registered here and reaches memory next cycle.
               if (accept) begin
                  addr_q    <= ptr;
                  wdata_q   <= rx_data;
                  we_q      <= 1'b1;
                  sum       <= sum + rx_data;
                  ptr       <= ptr + 8'd1;
                  remaining <= remaining - 9'd1;
                  if (remaining == 9'd1) begin
                     state <= LD_CSUM;
                  end
               end else if (expired) begin
                  state   <= LD_ERR;
                  error_q <= 1'b1;
               end
            end
            LD_CSUM: begin
               if (accept) begin
                  if (rx_data == sum) begin
                     state  <= LD_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state   <= LD_ERR;
                     error_q <= 1'b1;
                  end
               end else if (expired) begin
                  state   <= LD_ERR;
                  error_q <= 1'b1;
               end
            end
            LD_DONE: begin
               state <= LD_IDLE;
            end
            default: begin
               state <= LD_IDLE;
            end
         endcase
      end
   end

   assign cpu_hold  = (state != LD_IDLE);
   assign busy      = (state != LD_IDLE) && (state != LD_ERR);
   assign done      = done_q;
   assign error     = error_q;

   // Address mux: the loader owns the memory port whenever the CPU is held.
   assign mem_addr  = cpu_hold ? addr_q : cpu_address;
   assign mem_wdata = wdata_q;
   assign mem_we    = cpu_hold & we_q;
   assign cpu_data  = cpu_hold ? NOP_BYTE : mem_rdata;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames, checksum error, sync hunting,
// 256-byte wrap, timeout and mid-load reset, against a bench-side memory.
module tb_program_loader;

   localparam int unsigned TMO = 40;

   logic       clk;
   logic       reset;
   logic       load_req;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] cpu_address;
   logic [7:0] cpu_data;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic [7:0] mem_rdata;
   logic       cpu_hold;
   logic       busy;
   logic       done;
   logic       error;

   int n_cmp;
   int n_fail;
   int wr_cnt;
   int done_cnt;

   logic [7:0] tb_mem [0:255];
   logic [7:0] frame  [0:299];

   program_loader #(
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (TMO),
      .NOP_BYTE       (8'h70)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load_req    (load_req),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .cpu_address (cpu_address),
      .cpu_data    (cpu_data),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_rdata   (mem_rdata),
      .cpu_hold    (cpu_hold),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // program memory model: combinational read, write on posedge
   assign mem_rdata = tb_mem[mem_addr];
   always @(posedge clk) begin
      if (mem_we) begin
         tb_mem[mem_addr] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_load;
      load_req = 1'b1;
      tick(1);
      load_req = 1'b0;
   endtask

   task automatic send_bytes(input int n);
      for (int i = 0; i < n; i++) begin
         rx_data  = frame[i];
         rx_valid = 1'b1;
         tick(1);
      end
      rx_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      tick(3);
      cpu_address = 8'h3C;
      #1;
      n_cmp++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
      n_cmp++; if ({mem_we, cpu_hold, busy, done, error} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {mem_we, cpu_hold, busy, done, error}); end
      n_cmp++; if (mem_addr !== 8'h3C) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 3c", mem_addr); end
      n_cmp++; if (cpu_data !== (8'h3C ^ 8'h5A)) begin n_fail++; $display("FAIL reset_cpu_data: got %h want %h", cpu_data, 8'h3C ^ 8'h5A); end
      reset = 1'b1;
      tick(1);
   endtask

   task automatic test_good_frame;
      int w0, d0;
      w0 = wr_cnt; d0 = done_cnt;
      pulse_load();
      n_cmp++; if ({busy, cpu_hold, rx_ready} !== 3'b111) begin n_fail++; $display("FAIL load_start: got %b want 111", {busy, cpu_hold, rx_ready}); end
      n_cmp++; if (cpu_data !== 8'h70) begin n_fail++; $display("FAIL hold_nop: got %h want 70", cpu_data); end
      frame[0] = 8'hA5; frame[1] = 8'h03; frame[2] = 8'h11;
      frame[3] = 8'h22; frame[4] = 8'h33; frame[5] = 8'h66;
      send_bytes(6);
      n_cmp++; if ({done, cpu_hold} !== 2'b11) begin n_fail++; $display("FAIL good_done_cycle: got %b want 11", {done, cpu_hold}); end
      tick(1);
      n_cmp++; if ({done, cpu_hold, busy, error} !== 4'b0000) begin n_fail++; $display("FAIL good_release: got %b want 0000", {done, cpu_hold, busy, error}); end
      n_cmp++; if ({tb_mem[0], tb_mem[1], tb_mem[2]} !== 24'h112233) begin n_fail++; $display("FAIL good_image: got %h want 112233", {tb_mem[0], tb_mem[1], tb_mem[2]}); end
      n_cmp++; if (wr_cnt - w0 !== 3) begin n_fail++; $display("FAIL good_writes: got %0d want 3", wr_cnt - w0); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL good_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_bad_checksum;
      int d0;
      d0 = done_cnt;
      pulse_load();
      frame[5] = 8'h67;
      send_bytes(6);
      tick(3);
      n_cmp++; if ({error, cpu_hold, busy, rx_ready} !== 4'b1100) begin n_fail++; $display("FAIL bad_csum_state: got %b want 1100", {error, cpu_hold, busy, rx_ready}); end
      n_cmp++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL bad_csum_done: got %0d want 0", done_cnt - d0); end
      pulse_load();
      n_cmp++; if ({error, busy} !== 2'b01) begin n_fail++; $display("FAIL err_reload: got %b want 01", {error, busy}); end
   endtask

   // continues from the SYNC state entered at the end of test_bad_checksum
   task automatic test_sync_hunt;
      int w0, d0;
      w0 = wr_cnt; d0 = done_cnt;
      frame[0] = 8'h00; frame[1] = 8'hFF; frame[2] = 8'hA5;
      frame[3] = 8'h01; frame[4] = 8'h7F; frame[5] = 8'h7F;
      send_bytes(6);
      tick(1);
      n_cmp++; if ({tb_mem[0], tb_mem[1]} !== 16'h7F22) begin n_fail++; $display("FAIL hunt_image: got %h want 7f22", {tb_mem[0], tb_mem[1]}); end
      n_cmp++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL hunt_writes: got %0d want 1", wr_cnt - w0); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL hunt_done: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_full_256;
      int w0, d0, bad;
      w0 = wr_cnt; d0 = done_cnt; bad = 0;
      for (int i = 0; i < 256; i++) tb_mem[i] = 8'hEE;
      frame[0] = 8'hA5; frame[1] = 8'h00;
      for (int i = 0; i < 256; i++) frame[i + 2] = 8'(i);
      frame[258] = 8'h80;
      pulse_load();
      send_bytes(259);
      tick(1);
      for (int i = 0; i < 256; i++) if (tb_mem[i] !== 8'(i)) bad++;
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL full_image: got %0d bad bytes want 0", bad); end
      n_cmp++; if (wr_cnt - w0 !== 256) begin n_fail++; $display("FAIL full_writes: got %0d want 256", wr_cnt - w0); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL full_done: got %0d want 1", done_cnt - d0); end
      n_cmp++; if ({cpu_hold, busy, error} !== 3'b000) begin n_fail++; $display("FAIL full_release: got %b want 000", {cpu_hold, busy, error}); end
   endtask

   task automatic test_timeout;
      int w0;
      w0 = wr_cnt;
      tb_mem[2] = 8'h99;
      frame[0] = 8'hA5; frame[1] = 8'h04; frame[2] = 8'hD0; frame[3] = 8'hD1;
      pulse_load();
      send_bytes(4);
      tick(TMO - 1);
      n_cmp++; if ({error, busy} !== 2'b01) begin n_fail++; $display("FAIL tmo_early: got %b want 01", {error, busy}); end
      tick(1);
      n_cmp++; if ({error, busy, cpu_hold} !== 3'b101) begin n_fail++; $display("FAIL tmo_expired: got %b want 101", {error, busy, cpu_hold}); end
      rx_data = 8'hD2; rx_valid = 1'b1;
      tick(3);
      rx_valid = 1'b0;
      n_cmp++; if (tb_mem[2] !== 8'h99) begin n_fail++; $display("FAIL tmo_late_byte: got %h want 99", tb_mem[2]); end
      n_cmp++; if (wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL tmo_writes: got %0d want 2", wr_cnt - w0); end
   endtask

   task automatic test_reset_mid_load;
      frame[0] = 8'hA5; frame[1] = 8'h05; frame[2] = 8'hE0; frame[3] = 8'hE1;
      pulse_load();
      n_cmp++; if ({error, busy} !== 2'b01) begin n_fail++; $display("FAIL mid_reload: got %b want 01", {error, busy}); end
      send_bytes(4);
      pulse_load();
      frame[0] = 8'hE2;
      send_bytes(1);
      cpu_address = 8'h80;
      reset = 1'b0;
      tick(1);
      n_cmp++; if ({rx_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0) begin n_fail++; $display("FAIL mid_reset_flags: got %b want 000000", {rx_ready, mem_we, cpu_hold, busy, done, error}); end
      n_cmp++; if (mem_addr !== 8'h80) begin n_fail++; $display("FAIL mid_reset_addr: got %h want 80", mem_addr); end
      n_cmp++; if (cpu_data !== 8'h80) begin n_fail++; $display("FAIL mid_reset_cpu_data: got %h want 80", cpu_data); end
      reset = 1'b1;
      tick(1);
      n_cmp++; if ({tb_mem[0], tb_mem[1], tb_mem[2]} !== 24'hE0E1E2) begin n_fail++; $display("FAIL mid_partial_image: got %h want e0e1e2", {tb_mem[0], tb_mem[1], tb_mem[2]}); end
      cpu_address = 8'h01;
      #1;
      n_cmp++; if (cpu_data !== 8'hE1) begin n_fail++; $display("FAIL mid_cpu_fetch: got %h want e1", cpu_data); end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; wr_cnt = 0; done_cnt = 0;
      reset = 1'b0; load_req = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; cpu_address = 8'h00;
      for (int i = 0; i < 256; i++) tb_mem[i] = 8'(i) ^ 8'h5A;
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_sync_hunt();
      test_full_256();
      test_timeout();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
